// File: rtl/rstack_ctrl_if.sv
// Return-stack controller bus: the control-unit side (push/pop requests and
// stack status) plus the RAM port drives. The control unit and RAM model act as
// master; rstack_ctrl is the slave.
// Request semantics: push and pop are single-cycle strobes. The controller
// always accepts them in the cycle they are presented. There is no ready
// signal. Illegal requests (push while full, pop while empty) are dropped and
// leave the stack unchanged.
interface rstack_ctrl_if #(
    parameter int WIDTH      = 4,
    parameter int DATA_WIDTH = 13
);
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] push_data;
    logic [DATA_WIDTH-1:0] top;
    logic [WIDTH:0]        depth;
    logic                  empty;
    logic                  full;
    logic                  err_overflow;
    logic                  err_underflow;
    logic [WIDTH-1:0]      mem_dout_addr;
    logic [DATA_WIDTH-1:0] mem_dout;
    logic                  we;
    logic [WIDTH-1:0]      mem_din_addr;
    logic [DATA_WIDTH-1:0] mem_din;

    modport master (
        output push, pop, push_data, mem_dout,
        input  top, depth, empty, full, err_overflow, err_underflow,
        input  mem_dout_addr, we, mem_din_addr, mem_din
    );

    modport slave (
        input  push, pop, push_data, mem_dout,
        output top, depth, empty, full, err_overflow, err_underflow,
        output mem_dout_addr, we, mem_din_addr, mem_din
    );
endinterface

// File: rtl/rstack_ctrl.sv
// rstack_ctrl: return-stack sequencer. The top-of-stack entry lives in a
// register, so it has zero read latency. The entries below it live in an
// external 1R/1W RAM with asynchronous read and synchronous write, at
// RAM[0..depth-2]. Total capacity is SIZE+1.
// Optional feature macro: RSTACK_GUARD_EN. When defined, it adds sticky
// overflow and underflow error flags. When undefined, both flags are tied
// to 0. Saturation on illegal requests happens in both builds.
module rstack_ctrl #(
    parameter int WIDTH      = 4,
    parameter int SIZE       = 16,
    parameter int DATA_WIDTH = 13
) (
    input logic          clk,
    input logic          reset,
    rstack_ctrl_if.slave bus
);
    localparam logic [WIDTH:0] FULL_DEPTH = (WIDTH+1)'(SIZE + 1);

    logic [WIDTH:0]        r_depth;
    logic [DATA_WIDTH-1:0] r_top;

    logic w_empty;
    logic w_full;
    logic w_swap;
    logic w_push_only;
    logic w_pop_only;

    assign w_empty = (r_depth == '0);
    assign w_full  = (r_depth == FULL_DEPTH);

    // Push and pop together replace the TOS, which is legal even when full.
    // When the stack is empty, push+pop falls through to a plain push.
    assign w_swap      = bus.push && bus.pop && !w_empty;
    assign w_push_only = bus.push && !w_swap && !w_full;
    assign w_pop_only  = bus.pop && !bus.push && !w_empty;

    // RAM port drives are decoded from the current depth and TOS. A write
    // happens only on a push, and read data is used only on a pop, so the
    // two ports never collide on the same address.
    always_comb begin
        bus.we            = w_push_only && !w_empty;
        bus.mem_din_addr  = r_depth[WIDTH-1:0] - WIDTH'(1);
        bus.mem_din       = r_top;
        bus.mem_dout_addr = r_depth[WIDTH-1:0] - WIDTH'(2);
    end

    // Stack pointer and TOS register. Reset clears them asynchronously and
    // leaves the RAM untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_depth <= '0;
            r_top   <= '0;
        end else if (w_swap) begin
            r_top <= bus.push_data;
        end else if (w_push_only) begin
            r_top   <= bus.push_data;
            r_depth <= r_depth + (WIDTH+1)'(1);
        end else if (w_pop_only) begin
            r_top   <= (r_depth >= (WIDTH+1)'(2)) ? bus.mem_dout : '0;
            r_depth <= r_depth - (WIDTH+1)'(1);
        end
    end

    assign bus.top   = r_top;
    assign bus.depth = r_depth;
    assign bus.empty = w_empty;
    assign bus.full  = w_full;

`ifdef RSTACK_GUARD_EN
    logic r_err_ov;
    logic r_err_un;

    // Sticky error flags for dropped requests. Only reset clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_ov <= 1'b0;
            r_err_un <= 1'b0;
        end else begin
            if (bus.push && !bus.pop && w_full)
                r_err_ov <= 1'b1;
            if (bus.pop && !bus.push && w_empty)
                r_err_un <= 1'b1;
        end
    end

    assign bus.err_overflow  = r_err_ov;
    assign bus.err_underflow = r_err_un;
`else
    assign bus.err_overflow  = 1'b0;
    assign bus.err_underflow = 1'b0;
`endif
endmodule
